axi_lite_cmd_master: RTL and testbench
======================================

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 The block SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 8, AXI4-Lite address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: M_AXI_ACLK in 1, the single clock; M_AXI_ARESETN in 1, asynchronous active-low reset.
REQ-004 cmd_valid in 1; cmd_ready out 1; cmd_write in 1, 1=write, 0=read; cmd_addr in ADDR_W, byte address; cmd_wdata in 32; cmd_wstrb in 4.
REQ-005 rsp_valid out 1; rsp_ready in 1; rsp_rdata out 32; rsp_resp out 2, captured BRESP/RRESP; rsp_write out 1, echo of cmd_write.
REQ-006 busy out 1, high whenever the FSM is not in IDLE.
REQ-007 AW channel: M_AXI_AWADDR out ADDR_W; M_AXI_AWPROT out 3, constant 000; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
REQ-008 W channel: M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
REQ-009 B channel: M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
REQ-010 AR channel: M_AXI_ARADDR out ADDR_W; M_AXI_ARPROT out 3, constant 000; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
REQ-011 R channel: M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Function
REQ-012 The FSM SHALL have the states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and RESP.
REQ-013 cmd_ready SHALL equal (state==IDLE); a command is accepted on cmd_valid&&cmd_ready, and addr/data/strb/write are registered at that edge.
REQ-014 Captured addresses SHALL have bits [1:0] forced to 00 (word aligned); the upper bits pass unchanged.
REQ-015 A write command SHALL move IDLE->WR_ADDR_DATA, and AWVALID and WVALID SHALL both rise on the next cycle (1 cycle after acceptance).
REQ-016 AWVALID and WVALID SHALL each drop independently on their own handshake; the two handshakes may occur in the same cycle or in either order, with any gap.
REQ-017 Once both handshakes are done, the FSM SHALL enter WR_RESP with BREADY=1, and BVALID&&BREADY SHALL capture BRESP and move to RESP.
REQ-018 A read command SHALL move IDLE->RD_ADDR with ARVALID=1; ARVALID&&ARREADY SHALL move to RD_DATA with RREADY=1.
REQ-019 RVALID&&RREADY SHALL capture RDATA and RRESP and move to RESP.
REQ-020 No VALID SHALL deassert before its READY; address, data and strobe outputs SHALL remain stable while VALID is high.
REQ-021 BREADY SHALL be high only in WR_RESP, and RREADY only in RD_DATA.
REQ-022 In RESP, rsp_valid=1 with stable payload; rsp_valid&&rsp_ready SHALL return to IDLE, and a new command is accepted no earlier than the following cycle.
REQ-023 For writes, rsp_rdata SHALL be 0; non-OKAY responses (SLVERR/DECERR) SHALL be reported unchanged and SHALL NOT be retried.
REQ-024 There SHALL be at most one outstanding transaction; reads and writes are never overlapped.
REQ-025 Minimum latency with always-ready slaves: accept at T; AW/W handshake at T+1; B at T+2; rsp_valid at T+3.

Reset
REQ-026 Asserting M_AXI_ARESETN low SHALL immediately force state=IDLE, all VALID/READY outputs=0, rsp_valid=0, busy=0, captured registers=0.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no response produced; after release, cmd_ready SHALL be 1 on the first clock.

Structure
REQ-028 The state enum, the response codes OKAY=00/EXOKAY=01/SLVERR=10/DECERR=11 and ADDR_LSB=2 SHALL reside in a shared package, axi_lite_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; both AW/W "done" flags are registers within the FSM.

Verification
REQ-030 Write, always-ready slave: cmd addr 0x08, data 0x00000003, strb 0xF -> AWADDR=0x08, WDATA=0x3, rsp_resp=00, rsp_valid exactly 3 cycles after acceptance.
REQ-031 Skewed write: WREADY 4 cycles after AWREADY; cmd addr 0x0D -> AWADDR=0x0C, AWVALID drops after its handshake, WVALID held 4 more cycles, single response.
REQ-032 Read: cmd addr 0x04; slave returns RDATA=0x000000A5 with a 2-cycle ARREADY delay -> rsp_rdata=0xA5, rsp_write=0, resp=00.
REQ-033 Error plus backpressure: slave BRESP=10 and rsp_ready held low 5 cycles -> rsp payload stable throughout, cmd_ready=0 until rsp_ready.
REQ-034 Reset with AWVALID=1 pending -> all VALIDs=0 asynchronously, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: FSM state encoding, response codes and
// the word-alignment bit position used by the command master.
package axi_lite_pkg;

    localparam int ADDR_LSB = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE         = 3'd0;
    localparam state_t ST_WR_ADDR_DATA = 3'd1;
    localparam state_t ST_WR_RESP      = 3'd2;
    localparam state_t ST_RD_ADDR      = 3'd3;
    localparam state_t ST_RD_DATA      = 3'd4;
    localparam state_t ST_RESP         = 3'd5;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI
// read or write and returns the captured response on the rsp_* channel.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 8
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_write,

    output logic                              busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,

    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [AW-1:0] LSB_MASK = AW'((1 << ADDR_LSB) - 1);

    state_t            state_reg;
    logic [AW-1:0]     addr_reg;
    logic [DW-1:0]     wdata_reg;
    logic [DW/8-1:0]   wstrb_reg;
    logic              write_reg;
    logic              aw_done_reg;
    logic              w_done_reg;
    logic [DW-1:0]     rdata_reg;
    logic [1:0]        resp_reg;

    logic              aw_hs;
    logic              w_hs;

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

    // Everything below is a pure decode of registered state, so outputs
    // drop to their idle values the instant reset clears the registers.
    assign cmd_ready     = (state_reg == ST_IDLE);
    assign busy          = (state_reg != ST_IDLE);
    assign M_AXI_AWVALID = (state_reg == ST_WR_ADDR_DATA) && !aw_done_reg;
    assign M_AXI_WVALID  = (state_reg == ST_WR_ADDR_DATA) && !w_done_reg;
    assign M_AXI_BREADY  = (state_reg == ST_WR_RESP);
    assign M_AXI_ARVALID = (state_reg == ST_RD_ADDR);
    assign M_AXI_RREADY  = (state_reg == ST_RD_DATA);
    assign rsp_valid     = (state_reg == ST_RESP);

    assign M_AXI_AWADDR  = addr_reg;
    assign M_AXI_ARADDR  = addr_reg;
    assign M_AXI_WDATA   = wdata_reg;
    assign M_AXI_WSTRB   = wstrb_reg;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;

    assign rsp_rdata     = rdata_reg;
    assign rsp_resp      = resp_reg;
    assign rsp_write     = write_reg;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            write_reg   <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            rdata_reg   <= '0;
            resp_reg    <= RESP_OKAY;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_reg    <= cmd_addr & ~LSB_MASK;
                        wdata_reg   <= cmd_wdata;
                        wstrb_reg   <= cmd_wstrb;
                        write_reg   <= cmd_write;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        rdata_reg   <= '0;
                        resp_reg    <= RESP_OKAY;
                        state_reg   <= cmd_write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                    end
                end
                ST_WR_ADDR_DATA: begin
                    // AW and W complete independently; leave once both have.
                    if (aw_hs) aw_done_reg <= 1'b1;
                    if (w_hs)  w_done_reg  <= 1'b1;
                    if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs))
                        state_reg <= ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        resp_reg  <= M_AXI_BRESP;
                        state_reg <= ST_RESP;
                    end
                end
                ST_RD_ADDR: begin
                    if (M_AXI_ARREADY) state_reg <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        rdata_reg <= M_AXI_RDATA;
                        resp_reg  <= M_AXI_RRESP;
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: a cycle-driven AXI4-Lite slave
// model with programmable delays, and a response scoreboard.
module tb_axi_lite_cmd_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    axi_lite_cmd_master dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- slave model configuration and observations ----------
    int          aw_delay, w_delay, ar_delay, b_delay, r_delay;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    logic [7:0]  got_awaddr, got_araddr;
    logic [31:0] got_wdata;
    logic [3:0]  got_wstrb;
    int          aw_hs_cnt, w_hs_cnt, ar_hs_cnt, aw_vcyc, w_vcyc, stab_err;

    // All slave decisions are made at the falling edge, where DUT outputs
    // are settled; a VALID&&READY seen here completes at the next rising edge.
    initial begin
        int aw_wait, w_wait, ar_wait, b_wait, r_wait;
        bit aw_pend, w_pend, b_owed, r_owed, b_drop, r_drop, aw_seen, w_seen;
        logic [7:0]  aw_hold;
        logic [35:0] w_hold;
        aw_hs_cnt = 0; w_hs_cnt = 0; ar_hs_cnt = 0; aw_vcyc = 0; w_vcyc = 0; stab_err = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_pend = 0; w_pend = 0; b_owed = 0; r_owed = 0; b_drop = 0; r_drop = 0;
        aw_seen = 0; w_seen = 0; aw_hold = 0; w_hold = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                aw_pend = 0; w_pend = 0; b_owed = 0; r_owed = 0;
                b_drop = 0; r_drop = 0; aw_seen = 0; w_seen = 0;
                continue;
            end
            if (b_drop) begin bvalid = 0; b_drop = 0; end
            if (b_owed && !bvalid) begin
                if (b_wait >= b_delay) begin bvalid = 1; bresp = cfg_bresp; b_owed = 0; b_wait = 0; end
                else b_wait++;
            end
            if (bvalid && bready) b_drop = 1;

            if (r_drop) begin rvalid = 0; r_drop = 0; end
            if (r_owed && !rvalid) begin
                if (r_wait >= r_delay) begin
                    rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; r_owed = 0; r_wait = 0;
                end else r_wait++;
            end
            if (rvalid && rready) r_drop = 1;

            if (awvalid) begin
                aw_vcyc++;
                if (aw_seen && awaddr !== aw_hold) stab_err++;
                aw_seen = 1; aw_hold = awaddr;
                awready = (aw_wait >= aw_delay);
                if (awready) begin
                    got_awaddr = awaddr; aw_hs_cnt++; aw_pend = 1; aw_seen = 0; aw_wait = 0;
                end else aw_wait++;
            end else begin
                awready = 0; aw_wait = 0; aw_seen = 0;
            end

            if (wvalid) begin
                w_vcyc++;
                if (w_seen && {wstrb, wdata} !== w_hold) stab_err++;
                w_seen = 1; w_hold = {wstrb, wdata};
                wready = (w_wait >= w_delay);
                if (wready) begin
                    got_wdata = wdata; got_wstrb = wstrb; w_hs_cnt++; w_pend = 1; w_seen = 0; w_wait = 0;
                end else w_wait++;
            end else begin
                wready = 0; w_wait = 0; w_seen = 0;
            end
            if (aw_pend && w_pend) begin b_owed = 1; aw_pend = 0; w_pend = 0; end

            if (arvalid) begin
                arready = (ar_wait >= ar_delay);
                if (arready) begin got_araddr = araddr; ar_hs_cnt++; r_owed = 1; ar_wait = 0; end
                else ar_wait++;
            end else begin
                arready = 0; ar_wait = 0;
            end
        end
    end

    // ---------------- scoreboard and checking ----------------
    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] er, input logic [1:0] ersp);
        exp_t e;
        check("cmd_ready_before_issue", cmd_ready, 1);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        e.write = w; e.rdata = er; e.resp = ersp;
        sb.push_back(e);
    endtask

    // Counts falling edges from the acceptance cycle until rsp_valid shows.
    task automatic wait_rsp(output int lat);
        exp_t e;
        bit found;
        found = 0; lat = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            cmd_valid = 0;
            lat++;
            if (lat == 1) begin
                check("busy_after_accept", busy, 1);
                check("cmd_ready_after_accept", cmd_ready, 0);
            end
            if (rsp_valid === 1'b1) found = 1;
        end
        check("rsp_seen_in_budget", found, 1);
        e = sb.pop_front();
        if (found) begin
            check("rsp_write", rsp_write, e.write);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", rsp_resp, e.resp);
        end
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("cmd_ready_after_hs", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, aw0, w0, awv0, wv0;
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 1;
        aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        rst_n = 1;
        @(negedge clk);
        check("cmd_ready_after_release", cmd_ready, 1);

        // Write, always-ready slave
        send_cmd(1, 8'h08, 32'h0000_0003, 4'hF, 32'h0, 2'b00);
        wait_rsp(lat);
        check("wr_latency", lat, 3);
        check("wr_awaddr", got_awaddr, 8'h08);
        check("wr_wdata", got_wdata, 32'h3);
        check("wr_wstrb", got_wstrb, 4'hF);
        check("wr_awprot", awprot, 0);
        finish_rsp();

        // Skewed write: W accepted 4 cycles after AW, unaligned address
        w_delay = 4;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; awv0 = aw_vcyc; wv0 = w_vcyc;
        send_cmd(1, 8'h0D, 32'h1234_5678, 4'h3, 32'h0, 2'b00);
        wait_rsp(lat);
        check("skew_latency", lat, 7);
        check("skew_awaddr", got_awaddr, 8'h0C);
        check("skew_wdata", got_wdata, 32'h1234_5678);
        check("skew_aw_valid_cycles", aw_vcyc - awv0, 1);
        check("skew_w_valid_cycles", w_vcyc - wv0, 5);
        check("skew_aw_handshakes", aw_hs_cnt - aw0, 1);
        check("skew_w_handshakes", w_hs_cnt - w0, 1);
        finish_rsp();
        repeat (3) begin
            @(negedge clk);
            check("skew_single_rsp", rsp_valid, 0);
        end
        w_delay = 0;

        // Read with 2-cycle ARREADY delay
        ar_delay = 2; cfg_rdata = 32'h0000_00A5; cfg_rresp = 2'b00;
        send_cmd(0, 8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0000_00A5, 2'b00);
        wait_rsp(lat);
        check("rd_latency", lat, 5);
        check("rd_araddr", got_araddr, 8'h04);
        check("rd_arprot", arprot, 0);
        finish_rsp();
        ar_delay = 0;

        // Read returning DECERR at the top of the address space
        cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b11;
        send_cmd(0, 8'hFF, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b11);
        wait_rsp(lat);
        check("rd_err_latency", lat, 3);
        check("rd_err_araddr", got_araddr, 8'hFC);
        finish_rsp();

        // SLVERR write with response backpressure
        cfg_bresp = 2'b10; rsp_ready = 0;
        send_cmd(1, 8'h20, 32'hA5A5_0001, 4'h1, 32'h0, 2'b10);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_resp", rsp_resp, 2'b10);
            check("bp_rsp_rdata", rsp_rdata, 0);
            check("bp_rsp_write", rsp_write, 1);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1;
        finish_rsp();
        cfg_bresp = 2'b00;

        // Reset with AWVALID pending
        aw_delay = 100; w_delay = 100;
        send_cmd(1, 8'h30, 32'h0BAD_0BAD, 4'hF, 32'h0, 2'b00);
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("pre_rst_awvalid", awvalid, 1);
        check("pre_rst_wvalid", wvalid, 1);
        #2 rst_n = 0;
        #1;
        check("async_rst_awvalid", awvalid, 0);
        check("async_rst_wvalid", wvalid, 0);
        check("async_rst_arvalid", arvalid, 0);
        check("async_rst_bready", bready, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_awaddr", awaddr, 0);
        void'(sb.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1; aw_delay = 0; w_delay = 0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_rsp", rsp_valid, 0);
            check("post_rst_idle", busy, 0);
        end

        // Recovery write after reset
        send_cmd(1, 8'h10, 32'hCAFE_F00D, 4'h5, 32'h0, 2'b00);
        wait_rsp(lat);
        check("rec_latency", lat, 3);
        check("rec_awaddr", got_awaddr, 8'h10);
        check("rec_wdata", got_wdata, 32'hCAFE_F00D);
        check("rec_wstrb", got_wstrb, 4'h5);
        finish_rsp();

        check("scoreboard_empty", sb.size(), 0);
        check("valid_payload_stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
